// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin bus arbiter (CPU m0, DMA m1); optional watchdog via BUS_TIMEOUT_EN
module mem_bus_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_instr,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        m0_ready_q, m0_ready_d;
    logic        m1_ready_q, m1_ready_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        busy;

`ifdef BUS_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout_err_q, timeout_err_d;
`else
    logic [7:0]  unused_timeout_limit;
    assign unused_timeout_limit = TIMEOUT_CYCLES;
`endif

    // Next-state logic: arbitration in IDLE, completion/watchdog in BUSY, one-cycle ready in DONE
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        m0_ready_d = 1'b0;
        m1_ready_d = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_d = BUSY;
                    // On a tie, serve whoever did not complete last
                    if (m0_valid && m1_valid) begin
                        grant_d = ~last_q;
                    end else begin
                        grant_d = m1_valid;
                    end
`ifdef BUS_TIMEOUT_EN
                    cnt_d = 8'd0;
`endif
                end
            end
            BUSY: begin
                if (s_ready) begin
                    state_d = DONE;
                    last_d  = grant_q;
                    if (grant_q) begin
                        m1_ready_d = 1'b1;
                        m1_rdata_d = s_rdata;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_rdata_d = s_rdata;
                    end
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_CYCLES) begin
                    // Abandon the stalled access: owner completes with zero data and an error pulse
                    state_d       = DONE;
                    last_d        = grant_q;
                    timeout_err_d = 1'b1;
                    if (grant_q) begin
                        m1_ready_d = 1'b1;
                        m1_rdata_d = 32'd0;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_rdata_d = 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
`ifdef BUS_TIMEOUT_EN
            cnt_q         <= 8'd0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            m0_ready_q <= m0_ready_d;
            m1_ready_q <= m1_ready_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign busy     = (state_q == BUSY);
    assign s_valid  = busy;
    assign s_addr   = grant_q ? m1_addr : m0_addr;
    assign s_wdata  = grant_q ? m1_wdata : m0_wdata;
    assign s_wstrb  = busy ? (grant_q ? m1_wstrb : m0_wstrb) : 4'h0;
    assign s_instr  = busy & ~grant_q & m0_instr;
    assign grant    = grant_q;
    assign m0_ready = m0_ready_q;
    assign m1_ready = m1_ready_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

`ifdef BUS_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        grant, timeout_err;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(8'd4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_instr(s_instr), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        bit          m0_req;
        bit          m1_req;
        logic        instr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        bit          toggle_m0;
    } vec_t;

    typedef struct {
        bit          master;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  wstrb;
        logic        instr;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    bit          lo;
    logic [31:0] mdl_rd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(bit a, bit b, logic ins, logic [3:0] ws, logic [31:0] ad,
                                logic [31:0] wd, logic [31:0] rd, int d, bit t);
        vec_t v;
        v.m0_req = a; v.m1_req = b; v.instr = ins; v.wstrb = ws; v.addr = ad;
        v.wdata = wd; v.rdata = rd; v.delay = d; v.toggle_m0 = t;
        return v;
    endfunction

    // m1 sees a derived address/data so the two masters are distinguishable on the slave side
    task automatic push_req(input bit m, input vec_t v);
        exp_t e;
        e.master = m;
        e.addr   = m ? v.addr + 32'h100 : v.addr;
        e.wdata  = m ? ~v.wdata : v.wdata;
        e.rdata  = m ? ~v.rdata : v.rdata;
        e.wstrb  = v.wstrb;
        e.instr  = m ? 1'b0 : v.instr;
        sb.push_back(e);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_s_valid"}, s_valid, 0);
        chk({tag, "_s_wstrb"}, s_wstrb, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_m0_ready"}, m0_ready, 0);
        chk({tag, "_m1_ready"}, m1_ready, 0);
        chk({tag, "_m0_rdata"}, m0_rdata, 0);
        chk({tag, "_m1_rdata"}, m1_rdata, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        m0_valid = v.m0_req; m1_valid = v.m1_req; m0_instr = v.instr;
        m0_addr = v.addr; m0_wdata = v.wdata; m0_wstrb = v.wstrb;
        m1_addr = v.addr + 32'h100; m1_wdata = ~v.wdata; m1_wstrb = v.wstrb;
        if (v.m0_req && v.m1_req) begin
            push_req(~lo, v);
            push_req(lo, v);
        end else if (v.m0_req) begin
            push_req(1'b0, v);
        end else if (v.m1_req) begin
            push_req(1'b1, v);
        end
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            @(negedge clk);
            chk("s_valid", s_valid, 1);
            chk("grant", grant, e.master);
            chk("s_addr", s_addr, e.addr);
            chk("s_wdata", s_wdata, e.wdata);
            chk("s_wstrb", s_wstrb, e.wstrb);
            chk("s_instr", s_instr, e.instr);
            for (int i = 0; i < v.delay; i++) begin
                if (v.toggle_m0) m0_valid = ~m0_valid;
                @(negedge clk);
                chk("busy_s_valid", s_valid, 1);
                chk("busy_grant", grant, e.master);
                chk("busy_s_wstrb", s_wstrb, e.wstrb);
                chk("busy_s_wdata", s_wdata, e.wdata);
                chk("busy_no_ready", {m0_ready, m1_ready}, 0);
            end
            if (v.toggle_m0) m0_valid = 1'b0;
            s_ready = 1'b1;
            s_rdata = e.rdata;
            @(negedge clk);
            s_ready = 1'b0;
            s_rdata = 32'hBAD0_0BAD;
            mdl_rd[e.master] = e.rdata;
            lo = e.master;
            chk("done_m0_ready", m0_ready, e.master == 1'b0);
            chk("done_m1_ready", m1_ready, e.master == 1'b1);
            chk("done_m0_rdata", m0_rdata, mdl_rd[0]);
            chk("done_m1_rdata", m1_rdata, mdl_rd[1]);
            chk("done_s_valid", s_valid, 0);
            chk("done_timeout_err", timeout_err, 0);
            if (e.master) m1_valid = 1'b0;
            else m0_valid = 1'b0;
            @(negedge clk);
            chk("idle_ready", {m0_ready, m1_ready}, 0);
            chk("idle_s_valid", s_valid, 0);
            chk("idle_s_wstrb", s_wstrb, 0);
        end
    endtask

    initial begin
        vecs.push_back(mk(1, 0, 0, 4'h0, 32'h4000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1, 0));
        vecs.push_back(mk(1, 1, 1, 4'h0, 32'h1000_0000, 32'h1111_2222, 32'hA5A5_0001, 0, 0));
        vecs.push_back(mk(1, 1, 0, 4'h3, 32'h2000_0040, 32'hCAFE_F00D, 32'h0F0F_1234, 2, 0));
        vecs.push_back(mk(0, 1, 0, 4'hF, 32'h3000_0000, 32'hEDCB_A987, 32'h5555_AAAA, 3, 1));
        vecs.push_back(mk(1, 0, 1, 4'h0, 32'h0000_0100, 32'h0000_0000, 32'h1357_9BDF, 0, 0));
`ifndef BUS_TIMEOUT_EN
        vecs.push_back(mk(0, 1, 0, 4'h1, 32'h8000_0000, 32'h0000_00FF, 32'h2468_ACE0, 12, 0));
`endif

        reset_n = 1'b0;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
        lo = 1'b1; mdl_rd[0] = 0; mdl_rd[1] = 0;
        #1;
        check_reset_values("rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // slave ready while idle must be ignored
        @(negedge clk);
        s_ready = 1'b1; s_rdata = 32'hFFFF_0000;
        repeat (3) @(negedge clk);
        chk("idle_sready_ready", {m0_ready, m1_ready}, 0);
        chk("idle_sready_rdata0", m0_rdata, 0);
        chk("idle_sready_rdata1", m1_rdata, 0);
        s_ready = 1'b0;

        for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k]);

        // reset in the middle of an m1 access
        @(negedge clk);
        m1_valid = 1'b1; m1_addr = 32'h9000_0000; m1_wstrb = 4'hF;
        @(negedge clk);
        chk("pre_rst_busy", {s_valid, grant}, 2'b11);
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        m1_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        lo = 1'b1; mdl_rd[0] = 0; mdl_rd[1] = 0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_no_ready", {m0_ready, m1_ready}, 0);
        end
        run_vec(mk(1, 1, 0, 4'h0, 32'h4000_0020, 32'h0, 32'h7777_8888, 1, 0));

`ifdef BUS_TIMEOUT_EN
        begin
            int busy_cycles = 0;
            @(negedge clk);
            m0_valid = 1'b1; m0_addr = 32'h5000_0000; m0_wstrb = 4'h0; m0_instr = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (m0_ready) break;
                if (s_valid) busy_cycles++;
            end
            chk("to_busy_cycles", busy_cycles, 5);
            chk("to_m0_ready", m0_ready, 1);
            chk("to_m1_ready", m1_ready, 0);
            chk("to_m0_rdata", m0_rdata, 0);
            chk("to_err_pulse", timeout_err, 1);
            m0_valid = 1'b0;
            lo = 1'b0; mdl_rd[0] = 0;
            @(negedge clk);
            chk("to_err_one_cycle", timeout_err, 0);
            chk("to_ready_one_cycle", m0_ready, 0);

            @(negedge clk);
            m1_valid = 1'b1; m1_addr = 32'h5000_0100; m1_wstrb = 4'h0;
            @(negedge clk);
            repeat (4) @(negedge clk);
            chk("lim_still_busy", s_valid, 1);
            s_ready = 1'b1; s_rdata = 32'hC0DE_C0DE;
            @(negedge clk);
            s_ready = 1'b0; m1_valid = 1'b0;
            chk("lim_m1_ready", m1_ready, 1);
            chk("lim_m1_rdata", m1_rdata, 32'hC0DE_C0DE);
            chk("lim_no_err", timeout_err, 0);
            @(negedge clk);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
